reduce_share_arbiter: RTL and testbench
=======================================

// Module: reduce_share_arbiter
//
// PURPOSE
//   Shares one reduction unit (AND/OR/XOR reduce of a WIDTH-bit operand)
//   among NREQ requesters. Uses a round-robin grant, a valid/ready request
//   handshake per requester and a single valid/ready response channel tagged
//   with the requester id. Sits between requester blocks and the combinational
//   reduction gates; the gates' output is registered before it is returned.
//
// PARAMETERS
//   NREQ   4  number of requesters (>=2)
//   WIDTH  4  operand width in bits (>=2)
//   IDW    $clog2(NREQ)  derived, id width; not overridable
//
// PORTS
//   clk         in   1           clock, rising edge
//   rst_n       in   1           asynchronous reset, active low
//   req_valid   in   NREQ        bit i: requester i has a request
//   req_op      in   2*NREQ      [2i+1:2i] op of req i: 00 AND, 01 OR, 10 XOR, 11 reserved
//   req_data    in   NREQ*WIDTH  [WIDTH*i +: WIDTH] operand of requester i
//   req_ready   out  NREQ        bit i: request i accepted this cycle (one-hot or 0)
//   resp_valid  out  1           response available
//   resp_ready  in   1           consumer accepts response
//   resp_id     out  IDW         requester index of the response
//   resp_op     out  2           op of the response
//   resp_bit    out  1           reduction result
//   resp_err    out  1           1 when op was reserved (11); resp_bit is then 0
//   busy        out  1           state != IDLE
//
// BEHAVIOUR
//   - FSM states: IDLE, CALC, RESP. Reset (rst_n=0, async) -> IDLE.
//     Reset also gives ptr=0 and all registered outputs 0 (resp_valid, resp_id,
//     resp_op, resp_bit, resp_err). req_ready=0 and busy=0 while reset is held.
//   - IDLE: grant g = first i with req_valid[i]=1, scanning ptr, ptr+1, ...
//     with wrap mod NREQ. req_ready[g]=1 combinationally, all other bits 0.
//     The handshake completes in the same cycle. Latch data, op and id=g, then
//     go to CALC. With no valid request, stay in IDLE and req_ready=0.
//   - req_ready is 0 in CALC and RESP. Requesters hold valid/op/data until
//     ready and must not derive valid from ready.
//   - CALC (1 cycle): resp_bit <= &/|/^ of the latched data for op 00/01/10.
//     For op 11, resp_bit <= 0 and resp_err <= 1; otherwise resp_err <= 0.
//     Then go to RESP.
//   - RESP: resp_valid=1. resp_id/op/bit/err stay stable until the handshake.
//     On resp_ready=1: resp_valid <= 0, ptr <= (resp_id+1) mod NREQ (wraps
//     NREQ-1 -> 0), go to IDLE. With resp_ready=0, hold indefinitely.
//   - Latency: accept at cycle t -> resp_valid first high at t+2. A response
//     accepted at cycle u allows the next accept at u+1. Best-case throughput
//     is 1 request per 3 cycles.
//   - New req_valid arriving while busy is not accepted; it waits for IDLE.
//     Fairness: a requester that holds valid is served within NREQ grants.
//   - resp_ready arriving while not in RESP has no effect.
//   - rst_n asserted mid-transaction drops it: no response is ever produced
//     and ptr returns to 0.
//
// TESTING
//   1 Reset: rst_n=0 mid-RESP -> resp_valid=0, busy=0 immediately; after release
//     req_valid=0001 -> req_ready=0001 (ptr=0).
//   2 Ops: req0 data=4'b1111 op=00 -> resp_bit=1 at t+2. data=4'b0110:
//     op=01 -> 1, op=10 -> 0, op=00 -> 0. op=11 -> resp_bit=0, resp_err=1.
//   3 Round-robin: req_valid=1111 held, resp_ready=1 -> grants 0,1,2,3,0 on
//     successive IDLE cycles; resp_id matches each grant.
//   4 Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_valid, id, bit
//     stable; req_ready=0 throughout; accept occurs 1 cycle after resp_ready=1.
//   5 Wrap/skip: ptr=3, req_valid=0110 -> grant 1, then ptr=2 -> grant 2.
//     Grant 3 leaves ptr=0.
//   6 Latency: accept at t -> resp_valid high exactly at t+2; back-to-back
//     requests with resp_ready=1 -> accepts every 3 cycles.

Source files
------------

// File: rtl/reduce_share_arbiter.sv
// Round-robin arbiter sharing one AND/OR/XOR reduction unit among NREQ requesters.
// Each request takes three cycles: accept (IDLE), compute (CALC), then return the tagged response (RESP).
module reduce_share_arbiter #(
    parameter int  NREQ  = 4,
    parameter int  WIDTH = 4,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [2*NREQ-1:0]     req_op,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [1:0]            resp_op,
    output logic                  resp_bit,
    output logic                  resp_err,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       op_q, op_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_bit_q, resp_bit_d;
    logic             resp_err_q, resp_err_d;
    logic             gnt_found;
    logic [IDW-1:0]   gnt_id;

    function automatic logic reduce_op(input logic [1:0] op, input logic [WIDTH-1:0] d);
        case (op)
            2'b00:   return &d;
            2'b01:   return |d;
            2'b10:   return ^d;
            default: return 1'b0;
        endcase
    endfunction

    // First valid requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_found && req_valid[(int'(ptr_q) + k) % NREQ]) begin
                gnt_found = 1'b1;
                gnt_id    = IDW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        data_d       = data_q;
        op_d         = op_q;
        resp_valid_d = resp_valid_q;
        resp_bit_d   = resp_bit_q;
        resp_err_d   = resp_err_q;
        req_ready    = '0;
        case (state_q)
            IDLE: begin
                if (gnt_found && rst_n) begin
                    req_ready[gnt_id] = 1'b1;
                    id_d    = gnt_id;
                    data_d  = req_data[int'(gnt_id)*WIDTH +: WIDTH];
                    op_d    = req_op[2*int'(gnt_id) +: 2];
                    state_d = CALC;
                end
            end
            CALC: begin
                resp_bit_d   = reduce_op(op_q, data_q);
                resp_err_d   = (op_q == 2'b11);
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    ptr_d        = (id_q == IDW'(NREQ-1)) ? '0 : id_q + IDW'(1);
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            data_q       <= '0;
            op_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_bit_q   <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            data_q       <= data_d;
            op_q         <= op_d;
            resp_valid_q <= resp_valid_d;
            resp_bit_q   <= resp_bit_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = id_q;
    assign resp_op    = op_q;
    assign resp_bit   = resp_bit_q;
    assign resp_err   = resp_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_reduce_share_arbiter.sv
// Directed bench for reduce_share_arbiter: reset, ops, round-robin, backpressure, wrap, back-to-back timing.
module tb_reduce_share_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [7:0]  req_op;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_id;
    logic [1:0]  resp_op;
    logic        resp_bit;
    logic        resp_err;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    reduce_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_op(req_op), .req_data(req_data), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_op(resp_op), .resp_bit(resp_bit), .resp_err(resp_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drives one request, waits (bounded) for its response and accepts it.
    // Returns at the start of the cycle after the response handshake.
    task automatic run_txn(input logic [3:0] v, input logic [1:0] op, input logic [15:0] data,
                           input bit hold_valid, output logic [3:0] gnt, output int acc_cyc,
                           output int lat, output logic [1:0] id, output logic b,
                           output logic e, output logic [1:0] rop);
        req_valid  = v;
        req_op     = {4{op}};
        req_data   = data;
        resp_ready = 1'b0;
        #1;
        gnt     = req_ready;
        acc_cyc = cyc;
        lat     = 99;
        id      = 2'bxx;
        b       = 1'bx;
        e       = 1'bx;
        rop     = 2'bxx;
        if (gnt != 4'b0000) begin
            for (int k = 1; k <= 6 && lat == 99; k++) begin
                next_cycle();
                if (k == 1 && !hold_valid) req_valid = '0;
                if (resp_valid) lat = k;
            end
            id  = resp_id;
            b   = resp_bit;
            e   = resp_err;
            rop = resp_op;
            resp_ready = 1'b1;
            next_cycle();
            resp_ready = 1'b0;
        end
        if (!hold_valid) req_valid = '0;
    endtask

    task automatic test_reset();
        logic [3:0] g; int a, l; logic [1:0] id, rop; logic b, e;
        rst_n = 1'b0; req_valid = 4'b1111; req_op = '0; req_data = '0; resp_ready = 1'b0;
        next_cycle(); next_cycle();
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if ({resp_valid, resp_id, resp_op, resp_bit, resp_err} !== 7'b0) begin
            failures++; $display("FAIL reset_outputs got=%b exp=0000000", {resp_valid, resp_id, resp_op, resp_bit, resp_err});
        end
        req_valid = '0;
        rst_n = 1'b1;
        next_cycle();
        // Serve requester 1 so the pointer moves away from 0 before the mid-response reset.
        run_txn(4'b0010, 2'b01, 16'hFFFF, 1'b0, g, a, l, id, b, e, rop);
        checks++; if (g !== 4'b0010) begin failures++; $display("FAIL reset_pre_grant got=%b exp=0010", g); end
        req_valid = 4'b0100; req_op = 8'h00; req_data = 16'hFFFF;
        next_cycle(); req_valid = '0;
        next_cycle();
        checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL reset_in_resp got=%b exp=1", resp_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_mid_valid got=%b exp=0", resp_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_mid_busy got=%b exp=0", busy); end
        next_cycle();
        rst_n = 1'b1;
        req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL reset_ptr_zero got=%b exp=0001", req_ready); end
        req_valid = '0;
        next_cycle(); next_cycle(); next_cycle();
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_no_resp got=%b exp=0", resp_valid); end
    endtask

    task automatic test_ops();
        logic [3:0] dv[7]  = '{4'b1111, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0111, 4'b0000};
        logic [1:0] ov[7]  = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b11, 2'b10, 2'b01};
        logic       bv[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       ev[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [3:0] g; int a, l; logic [1:0] id, rop; logic b, e;
        for (int i = 0; i < 7; i++) begin
            run_txn(4'b0001, ov[i], {4{dv[i]}}, 1'b0, g, a, l, id, b, e, rop);
            checks++; if (g !== 4'b0001) begin failures++; $display("FAIL ops%0d_grant got=%b exp=0001", i, g); end
            checks++; if (l !== 2) begin failures++; $display("FAIL ops%0d_latency got=%0d exp=2", i, l); end
            checks++; if (b !== bv[i]) begin failures++; $display("FAIL ops%0d_bit got=%b exp=%b", i, b, bv[i]); end
            checks++; if (e !== ev[i]) begin failures++; $display("FAIL ops%0d_err got=%b exp=%b", i, e, ev[i]); end
            checks++; if (rop !== ov[i] || id !== 2'd0) begin
                failures++; $display("FAIL ops%0d_tag got=op%b/id%0d exp=op%b/id0", i, rop, id, ov[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] eg[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [1:0] ei[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic       eb[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [3:0] g; int a, l; logic [1:0] id, rop; logic b, e;
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            // Requester data: r3=1000, r2=0000, r1=0011, r0=0000, all OR.
            run_txn(4'b1111, 2'b01, 16'h8030, 1'b1, g, a, l, id, b, e, rop);
            checks++; if (g !== eg[i]) begin failures++; $display("FAIL rr%0d_grant got=%b exp=%b", i, g, eg[i]); end
            checks++; if (id !== ei[i]) begin failures++; $display("FAIL rr%0d_id got=%0d exp=%0d", i, id, ei[i]); end
            checks++; if (b !== eb[i]) begin failures++; $display("FAIL rr%0d_bit got=%b exp=%b", i, b, eb[i]); end
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        req_valid = 4'b1111; req_op = {4{2'b10}}; req_data = {4{4'b0111}}; resp_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_grant got=%b exp=0010", req_ready); end
        next_cycle(); next_cycle();
        checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_start got=%b exp=1", resp_valid); end
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            checks++; if ({resp_valid, resp_id, resp_bit} !== 4'b1011) begin
                failures++; $display("FAIL bp_hold%0d got=v%b/id%0d/b%b exp=v1/id1/b1", i, resp_valid, resp_id, resp_bit);
            end
            checks++; if (req_ready !== 4'b0000 || busy !== 1'b1) begin
                failures++; $display("FAIL bp_ready%0d got=r%b/busy%b exp=r0000/busy1", i, req_ready, busy);
            end
        end
        resp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready_hs got=%b exp=0000", req_ready); end
        next_cycle();
        resp_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0100 || resp_valid !== 1'b0) begin
            failures++; $display("FAIL bp_next_accept got=r%b/v%b exp=r0100/v0", req_ready, resp_valid);
        end
        req_valid = '0;
        next_cycle();
    endtask

    task automatic test_wrap();
        logic [3:0] vv[5] = '{4'b0100, 4'b0110, 4'b0110, 4'b1000, 4'b1111};
        logic [3:0] eg[5] = '{4'b0100, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [1:0] ei[5] = '{2'd2, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [3:0] g; int a, l; logic [1:0] id, rop; logic b, e;
        for (int i = 0; i < 5; i++) begin
            run_txn(vv[i], 2'b00, 16'hFFFF, 1'b0, g, a, l, id, b, e, rop);
            checks++; if (g !== eg[i]) begin failures++; $display("FAIL wrap%0d_grant got=%b exp=%b", i, g, eg[i]); end
            checks++; if (id !== ei[i]) begin failures++; $display("FAIL wrap%0d_id got=%0d exp=%0d", i, id, ei[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] eg[3] = '{4'b0010, 4'b0100, 4'b1000};
        int acc[3];
        logic [3:0] g; int l; logic [1:0] id, rop; logic b, e;
        for (int i = 0; i < 3; i++) begin
            run_txn(4'b1111, 2'b00, 16'hFFFF, 1'b1, g, acc[i], l, id, b, e, rop);
            checks++; if (g !== eg[i]) begin failures++; $display("FAIL b2b%0d_grant got=%b exp=%b", i, g, eg[i]); end
            checks++; if (l !== 2) begin failures++; $display("FAIL b2b%0d_latency got=%0d exp=2", i, l); end
        end
        req_valid = '0;
        for (int i = 1; i < 3; i++) begin
            checks++; if (acc[i] - acc[i-1] !== 3) begin
                failures++; $display("FAIL b2b%0d_spacing got=%0d exp=3", i, acc[i] - acc[i-1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
